// File: rtl/bist_seq_controller_pkg.sv
// Shared BIST sequencer definitions: state encoding and default session sizing,
// also used by the pattern generator and MISR blocks.
package bist_seq_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_RUNNING = 3'd2,
        ST_COMPARE = 3'd3,
        ST_FINISH  = 3'd4,
        ST_DONE    = 3'd5
    } bist_state_e;

    localparam int unsigned BIST_NCLOCK_DEF  = 650;
    localparam int unsigned BIST_NROUNDS_DEF = 1;

endpackage

// File: rtl/bist_start_edge.sv
// Start-request edge detector. The history register resets to 1 so a start
// held high across reset release is not mistaken for a new request.
module bist_start_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    output logic start_rise
);

    logic start_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_q <= 1'b1;
        end else begin
            start_q <= start;
        end
    end

    assign start_rise = start & ~start_q;

endmodule

// File: rtl/bist_seq_controller.sv
// Multi-round BIST sequencer: NROUNDS rounds of NCLOCK stimulus cycles, signature
// check per round, latched pass/abort result. Optional COMPARE timeout: BIST_CMP_TIMEOUT_EN.
module bist_seq_controller
    import bist_seq_controller_pkg::*;
#(
    parameter int unsigned NCLOCK      = BIST_NCLOCK_DEF,
    parameter int unsigned NROUNDS     = BIST_NROUNDS_DEF,
    parameter int unsigned SIG_W       = 16,
    parameter int unsigned CMP_TIMEOUT = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic                             abort,
    input  logic [SIG_W-1:0]                 sig_in,
    input  logic                             sig_valid,
    input  logic [SIG_W-1:0]                 golden_sig,
    output logic                             init,
    output logic                             running,
    output logic                             toggle,
    output logic [$clog2(NROUNDS+1)-1:0]     round_idx,
    output logic                             finish,
    output logic                             bist_end,
    output logic                             pass,
    output logic                             aborted
);

    localparam int unsigned CNT_W = $clog2(NCLOCK);
    localparam int unsigned RND_W = $clog2(NROUNDS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCLOCK - 1);
    localparam logic [RND_W-1:0] RND_LAST = RND_W'(NROUNDS - 1);

    bist_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RND_W-1:0]  round_q, round_d;
    logic              pass_acc_q, pass_acc_d;
    logic              aborted_q, aborted_d;
    logic              pass_q, pass_d;
    logic              bist_end_q, bist_end_d;
    logic              start_rise;
    logic              cmp_timeout;

    bist_start_edge u_start_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_rise (start_rise)
    );

`ifdef BIST_CMP_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(CMP_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CMP_TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Counts cycles spent in the current COMPARE; cleared whenever COMPARE is left.
    always_comb begin
        tmo_d = '0;
        if (state_q == ST_COMPARE && state_d == ST_COMPARE) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign cmp_timeout = (tmo_q == TMO_LAST);
`else
    assign cmp_timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        round_d    = round_q;
        pass_acc_d = pass_acc_q;
        aborted_d  = aborted_q;
        pass_d     = pass_q;
        bist_end_d = bist_end_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_rise) begin
                    state_d    = ST_INIT;
                    pass_acc_d = 1'b1;
                    aborted_d  = 1'b0;
                    round_d    = '0;
                    bist_end_d = 1'b0;
                    pass_d     = 1'b0;
                end
            end
            ST_INIT: begin
                cnt_d = '0;
                if (abort) begin
                    state_d   = ST_FINISH;
                    aborted_d = 1'b1;
                end else begin
                    state_d = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (abort) begin
                    state_d   = ST_FINISH;
                    aborted_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_COMPARE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_COMPARE: begin
                if (abort) begin
                    state_d   = ST_FINISH;
                    aborted_d = 1'b1;
                end else if (sig_valid || cmp_timeout) begin
                    // A timeout carries sig_valid=0 and therefore counts as a mismatch.
                    pass_acc_d = pass_acc_q & sig_valid & (sig_in == golden_sig);
                    if (round_q == RND_LAST) begin
                        state_d = ST_FINISH;
                    end else begin
                        round_d = round_q + 1'b1;
                        state_d = ST_INIT;
                    end
                end
            end
            ST_FINISH: begin
                pass_d     = pass_acc_q & ~aborted_q;
                bist_end_d = 1'b1;
                state_d    = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            round_q    <= '0;
            pass_acc_q <= 1'b0;
            aborted_q  <= 1'b0;
            pass_q     <= 1'b0;
            bist_end_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            round_q    <= round_d;
            pass_acc_q <= pass_acc_d;
            aborted_q  <= aborted_d;
            pass_q     <= pass_d;
            bist_end_q <= bist_end_d;
        end
    end

    assign init      = (state_q == ST_INIT);
    assign running   = (state_q == ST_RUNNING);
    assign toggle    = running & ~cnt_q[0];
    assign finish    = (state_q == ST_FINISH);
    assign round_idx = round_q;
    assign bist_end  = bist_end_q;
    assign pass      = pass_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_bist_seq_controller.sv
// Randomised and directed bench for bist_seq_controller against a round/position
// reference model; honours BIST_CMP_TIMEOUT_EN when the design is built with it.
module tb_bist_seq_controller;

    localparam int NCLOCK      = 10;
    localparam int NROUNDS     = 2;
    localparam int SIG_W       = 16;
    localparam int CMP_TIMEOUT = 4;
    localparam int RND_W       = $clog2(NROUNDS + 1);

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b1;
    logic             abort = 1'b0;
    logic [SIG_W-1:0] sig_in = '0;
    logic             sig_valid = 1'b0;
    logic [SIG_W-1:0] golden_sig = '0;
    logic             init, running, toggle, finish, bist_end, pass, aborted;
    logic [RND_W-1:0] round_idx;

    int total = 0;
    int bad   = 0;
    bit tb_done = 1'b0;

    bist_seq_controller #(
        .NCLOCK      (NCLOCK),
        .NROUNDS     (NROUNDS),
        .SIG_W       (SIG_W),
        .CMP_TIMEOUT (CMP_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .sig_in     (sig_in),
        .sig_valid  (sig_valid),
        .golden_sig (golden_sig),
        .init       (init),
        .running    (running),
        .toggle     (toggle),
        .round_idx  (round_idx),
        .finish     (finish),
        .bist_end   (bist_end),
        .pass       (pass),
        .aborted    (aborted)
    );

    always #5 clk = ~clk;

    // Reference model. m_pos is the position inside a round:
    // 0 = seed cycle, 1..NCLOCK = stimulus cycles, >NCLOCK = waiting for signature.
    bit m_prev_start = 1'b1;
    bit m_active = 1'b0;
    bit m_fin = 1'b0;
    bit m_end = 1'b0;
    bit m_pass = 1'b0;
    bit m_abt = 1'b0;
    bit m_acc = 1'b0;
    int m_pos = 0;
    int m_round = 0;
`ifdef BIST_CMP_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_prev_start = 1'b1;
            m_active = 1'b0; m_fin = 1'b0; m_end = 1'b0;
            m_pass = 1'b0; m_abt = 1'b0; m_acc = 1'b0;
            m_pos = 0; m_round = 0;
        end else begin
            bit rise;
            rise = start && !m_prev_start;
            m_prev_start = start;
            if (m_fin) begin
                m_fin  = 1'b0;
                m_end  = 1'b1;
                m_pass = m_acc && !m_abt;
            end else if (m_active) begin
                if (abort) begin
                    m_active = 1'b0; m_fin = 1'b1; m_abt = 1'b1;
                end else if (m_pos <= NCLOCK) begin
                    m_pos++;
                end else if (sig_valid || (TMO_EN && (m_pos - NCLOCK - 1 == CMP_TIMEOUT - 1))) begin
                    m_acc = m_acc && sig_valid && (sig_in == golden_sig);
                    if (m_round == NROUNDS - 1) begin
                        m_active = 1'b0; m_fin = 1'b1;
                    end else begin
                        m_round++; m_pos = 0;
                    end
                end else begin
                    m_pos++;
                end
            end else if (rise) begin
                m_active = 1'b1; m_pos = 0; m_round = 0; m_acc = 1'b1;
                m_abt = 1'b0; m_end = 1'b0; m_pass = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    int n_init = 0, n_run = 0, n_tog = 0, n_fin = 0;

    always @(negedge clk) begin
        if (!tb_done) begin
            bit e_run;
            e_run = m_active && m_pos >= 1 && m_pos <= NCLOCK;
            chk("init",      32'(init),      32'(m_active && m_pos == 0));
            chk("running",   32'(running),   32'(e_run));
            chk("toggle",    32'(toggle),    32'(e_run && (m_pos % 2 == 1)));
            chk("round_idx", 32'(round_idx), 32'(m_round));
            chk("finish",    32'(finish),    32'(m_fin));
            chk("bist_end",  32'(bist_end),  32'(m_end));
            chk("pass",      32'(pass),      32'(m_pass));
            chk("aborted",   32'(aborted),   32'(m_abt));
            n_init += int'(init);
            n_run  += int'(running);
            n_tog  += int'(toggle);
            n_fin  += int'(finish);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
    endtask

    task automatic wait_cmp(input string nm);
        int i;
        for (i = 0; i < 60; i++) begin
            if (m_active && m_pos > NCLOCK) break;
            tick();
        end
        if (i == 60) chk({nm, "_wait_cmp_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_pos(input string nm, input int p);
        int i;
        for (i = 0; i < 60; i++) begin
            if (m_active && m_pos == p) break;
            tick();
        end
        if (i == 60) chk({nm, "_wait_pos_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic give_sig(input string nm, input logic [SIG_W-1:0] s, input logic [SIG_W-1:0] g);
        wait_cmp(nm);
        sig_in = s; golden_sig = g; sig_valid = 1'b1;
        tick();
        sig_valid = 1'b0;
    endtask

    task automatic wait_end(input string nm);
        int i;
        for (i = 0; i < 60; i++) begin
            if (bist_end) break;
            tick();
        end
        if (i == 60) chk({nm, "_wait_end_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        int b_init, b_run, b_tog, b_fin;

        // Start held high through reset release must not open a session.
        repeat (3) tick();
        reset_n = 1'b1;
        b_init = n_init; b_run = n_run;
        repeat (20) tick();
        chk("t1_no_init", 32'(n_init - b_init), 32'd0);
        chk("t1_no_run",  32'(n_run - b_run),   32'd0);
        chk("t1_bist_end", 32'(bist_end), 32'd0);

        // Two matching rounds.
        b_init = n_init; b_run = n_run; b_tog = n_tog; b_fin = n_fin;
        start_session();
        give_sig("t2r0", 16'h1234, 16'h1234);
        give_sig("t2r1", 16'hA5A5, 16'hA5A5);
        wait_end("t2");
        tick();
        chk("t2_init_cnt",   32'(n_init - b_init), 32'd2);
        chk("t2_run_cnt",    32'(n_run - b_run),   32'd20);
        chk("t2_toggle_cnt", 32'(n_tog - b_tog),   32'd10);
        chk("t2_finish_cnt", 32'(n_fin - b_fin),   32'd1);
        chk("t2_pass",       32'(pass),            32'd1);
        chk("t2_aborted",    32'(aborted),         32'd0);

        // Round 1 signature mismatch.
        b_run = n_run;
        start_session();
        give_sig("t3r0", 16'h0F0F, 16'h0F0F);
        give_sig("t3r1", 16'hBEEF, 16'hBEE0);
        wait_end("t3");
        tick();
        chk("t3_run_cnt", 32'(n_run - b_run), 32'd20);
        chk("t3_end",     32'(bist_end),      32'd1);
        chk("t3_pass",    32'(pass),          32'd0);
        chk("t3_aborted", 32'(aborted),       32'd0);

        // Abort on the fourth stimulus cycle of round 0.
        b_run = n_run; b_tog = n_tog;
        start_session();
        wait_pos("t4", 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_finish",  32'(finish),  32'd1);
        chk("t4_running", 32'(running), 32'd0);
        tick();
        chk("t4_end",     32'(bist_end), 32'd1);
        chk("t4_aborted", 32'(aborted),  32'd1);
        chk("t4_pass",    32'(pass),     32'd0);
        chk("t4_run_cnt", 32'(n_run - b_run), 32'd4);
        chk("t4_tog_cnt", 32'(n_tog - b_tog), 32'd2);

        // Start rise mid-session is ignored; a rise in DONE restarts.
        b_init = n_init; b_run = n_run; b_fin = n_fin;
        start_session();
        wait_pos("t5", 3);
        start_session();
        give_sig("t5r0", 16'h0001, 16'h0001);
        give_sig("t5r1", 16'h0002, 16'h0002);
        wait_end("t5");
        tick();
        chk("t5_init_cnt", 32'(n_init - b_init), 32'd2);
        chk("t5_run_cnt",  32'(n_run - b_run),   32'd20);
        chk("t5_fin_cnt",  32'(n_fin - b_fin),   32'd1);
        start_session();
        chk("t5_restart_end",  32'(bist_end), 32'd0);
        chk("t5_restart_init", 32'(init),     32'd1);
        give_sig("t5br0", 16'h7777, 16'h7777);
        give_sig("t5br1", 16'h8888, 16'h8888);
        wait_end("t5b");
        tick();
        chk("t5_restart_pass", 32'(pass), 32'd1);

        // No signature ever arrives.
        start_session();
        wait_cmp("t6");
        repeat (30) tick();
`ifdef BIST_CMP_TIMEOUT_EN
        chk("t6_tmo_end",     32'(bist_end), 32'd1);
        chk("t6_tmo_pass",    32'(pass),     32'd0);
        chk("t6_tmo_aborted", 32'(aborted),  32'd0);
`else
        chk("t6_stuck_end",   32'(bist_end),  32'd0);
        chk("t6_stuck_round", 32'(round_idx), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_abort_finish", 32'(finish), 32'd1);
        tick();
        chk("t6_abort_aborted", 32'(aborted), 32'd1);
`endif

        // Asynchronous reset in the middle of a stimulus run.
        start_session();
        wait_pos("trst", 5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_running", 32'(running),  32'd0);
        chk("rst_toggle",  32'(toggle),   32'd0);
        chk("rst_init",    32'(init),     32'd0);
        chk("rst_finish",  32'(finish),   32'd0);
        chk("rst_end",     32'(bist_end), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;

        // Randomised traffic checked cycle by cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            start      = ($urandom_range(0, 5) == 0) ? ~start : start;
            abort      = ($urandom_range(0, 59) == 0);
            sig_valid  = ($urandom_range(0, 2) == 0);
            golden_sig = SIG_W'($urandom);
            sig_in     = ($urandom_range(0, 3) == 0) ? (golden_sig ^ SIG_W'(1 << $urandom_range(0, SIG_W - 1)))
                                                     : golden_sig;
            tick();
        end

        tb_done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
